// File: rtl/obi_addr_map_ctrl_pkg.sv
// obi_addr_map_ctrl_pkg: register offsets, FSM states and rule address type for the address-map controller
package obi_addr_map_ctrl_pkg;

    localparam logic [11:0] RULE_STRIDE    = 12'h010;
    localparam logic [11:0] RULE_START_OFF = 12'h000;
    localparam logic [11:0] RULE_END_OFF   = 12'h004;
    localparam logic [11:0] RULE_IDX_OFF   = 12'h008;
    localparam logic [11:0] CTRL_OFF       = 12'h800;
    localparam logic [11:0] STATUS_OFF     = 12'h804;
    localparam logic [11:0] DEF_EN_OFF     = 12'h808;
    localparam logic [11:0] DEF_IDX_OFF    = 12'h900;

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_e;

    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rng_t;

endpackage

// File: rtl/obi_outstanding_cnt.sv
// obi_outstanding_cnt: one crossbar port's outstanding-transaction counter and handshake-safe block bit
module obi_outstanding_cnt #(
    parameter  int unsigned NumMaxTrans = 4,
    localparam int unsigned CntW        = $clog2(NumMaxTrans + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic gnt_i,
    input  logic rvalid_i,
    input  logic drain_i,
    output logic block_o,
    output logic idle_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            block_q, block_d;
    logic            inc, dec;

    always_comb begin
        inc     = req_i && gnt_i;
        dec     = rvalid_i;
        cnt_d   = (inc && !dec && cnt_q != CntW'(NumMaxTrans)) ? cnt_q + 1'b1 :
                  (dec && !inc && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        block_d = drain_i && (block_q || !req_i || gnt_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            block_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            block_q <= block_d;
        end
    end

    assign block_o = block_q;
    assign idle_o  = cnt_q == '0;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(inc && !dec && cnt_q == CntW'(NumMaxTrans)));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec && !inc && cnt_q == '0));

endmodule

// File: rtl/obi_addr_map_ctrl.sv
// obi_addr_map_ctrl: shadow/active crossbar address map, drain-then-commit update; OBI_ADDR_MAP_CTRL_TIMEOUT_EN aborts stuck drains
module obi_addr_map_ctrl
    import obi_addr_map_ctrl_pkg::*;
#(
    parameter  int unsigned NumSbrPorts   = 2,
    parameter  int unsigned NumMgrPorts   = 4,
    parameter  int unsigned NumAddrRules  = 4,
    parameter  int unsigned NumMaxTrans   = 4,
    parameter  int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdxW          = (NumMgrPorts > 1) ? $clog2(NumMgrPorts) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               cfg_req_i,
    output logic                               cfg_gnt_o,
    input  logic [11:0]                        cfg_addr_i,
    input  logic                               cfg_we_i,
    input  logic [31:0]                        cfg_wdata_i,
    output logic                               cfg_rvalid_o,
    output logic [31:0]                        cfg_rdata_o,
    output logic                               cfg_err_o,
    input  logic [NumSbrPorts-1:0]             mon_req_i,
    input  logic [NumSbrPorts-1:0]             mon_gnt_i,
    input  logic [NumSbrPorts-1:0]             mon_rvalid_i,
    output logic [NumSbrPorts-1:0]             block_o,
    output logic [NumAddrRules*(IdxW+64)-1:0]  addr_map_o,
    output logic [NumSbrPorts-1:0]             en_default_idx_o,
    output logic [NumSbrPorts*IdxW-1:0]        default_idx_o,
    output logic                               busy_o
);

    typedef struct packed {
        logic [IdxW-1:0] idx;
        addr_rng_t       rng;
    } rule_t;

    if (NumAddrRules < 1 || NumAddrRules > 64 || TimeoutCycles < 1) begin : g_bad_params
        $error("obi_addr_map_ctrl: NumAddrRules must be 1..64 and TimeoutCycles nonzero");
    end

    state_e                           state_q, state_d;
    rule_t [NumAddrRules-1:0]         sh_rule_q, sh_rule_d, act_rule_q, act_rule_d;
    logic  [NumSbrPorts-1:0]          sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic  [NumSbrPorts-1:0][IdxW-1:0] sh_didx_q, sh_didx_d, act_didx_q, act_didx_d;
    logic                             rvalid_q, rvalid_d, err_q, err_d;
    logic  [31:0]                     rdata_q, rdata_d, rd;
    logic  [NumSbrPorts-1:0]          idle;
    logic                             wr, hit, err, commit_go, drain_next, expired, timeout;

`ifdef OBI_ADDR_MAP_CTRL_TIMEOUT_EN
    localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;
    always_comb begin
        timer_d   = (state_q == DRAIN) ? timer_q + 1'b1 : '0;
        timeout_d = commit_go ? 1'b0 : (state_q == DRAIN && state_d == IDLE) ? 1'b1 : timeout_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end
    assign expired = timer_q == TW'(TimeoutCycles - 1);
    assign timeout = timeout_q;
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        sh_rule_d = sh_rule_q;
        sh_en_d   = sh_en_q;
        sh_didx_d = sh_didx_q;
        wr        = cfg_req_i && cfg_we_i;
        hit       = 1'b0;
        rd        = '0;
        for (int r = 0; r < NumAddrRules; r++) begin
            if (cfg_addr_i == RULE_STRIDE * 12'(r) + RULE_START_OFF) begin
                hit = 1'b1;
                rd  = sh_rule_q[r].rng.start_addr;
                if (wr) sh_rule_d[r].rng.start_addr = cfg_wdata_i;
            end
            if (cfg_addr_i == RULE_STRIDE * 12'(r) + RULE_END_OFF) begin
                hit = 1'b1;
                rd  = sh_rule_q[r].rng.end_addr;
                if (wr) sh_rule_d[r].rng.end_addr = cfg_wdata_i;
            end
            if (cfg_addr_i == RULE_STRIDE * 12'(r) + RULE_IDX_OFF) begin
                hit = 1'b1;
                rd  = 32'(sh_rule_q[r].idx);
                if (wr) sh_rule_d[r].idx = cfg_wdata_i[IdxW-1:0];
            end
        end
        for (int k = 0; k < NumSbrPorts; k++) begin
            if (cfg_addr_i == DEF_IDX_OFF + 12'(4 * k)) begin
                hit = 1'b1;
                rd  = 32'(sh_didx_q[k]);
                if (wr) sh_didx_d[k] = cfg_wdata_i[IdxW-1:0];
            end
        end
        if (cfg_addr_i == DEF_EN_OFF) begin
            hit = 1'b1;
            rd  = 32'(sh_en_q);
            if (wr) sh_en_d = cfg_wdata_i[NumSbrPorts-1:0];
        end
        if (cfg_addr_i == STATUS_OFF) begin
            hit = 1'b1;
            rd  = {30'b0, timeout, busy_o};
        end
        hit       = hit || cfg_addr_i == CTRL_OFF;
        commit_go = wr && cfg_addr_i == CTRL_OFF && cfg_wdata_i[0] && !busy_o;
        err       = !hit || (wr && cfg_addr_i == STATUS_OFF) ||
                    (wr && cfg_addr_i == CTRL_OFF && cfg_wdata_i[0] && busy_o);
        rvalid_d  = cfg_req_i;
        err_d     = cfg_req_i && err;
        rdata_d   = (cfg_req_i && !cfg_we_i && !err) ? rd : '0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = commit_go ? DRAIN : IDLE;
            DRAIN:   state_d = (&block_o && &idle) ? COMMIT : expired ? IDLE : DRAIN;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = state_q != IDLE;
        drain_next = state_d == DRAIN;
        act_rule_d = (state_q == COMMIT) ? sh_rule_q : act_rule_q;
        act_en_d   = (state_q == COMMIT) ? sh_en_q : act_en_q;
        act_didx_d = (state_q == COMMIT) ? sh_didx_q : act_didx_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sh_rule_q  <= '0;
            sh_en_q    <= '0;
            sh_didx_q  <= '0;
            act_rule_q <= '0;
            act_en_q   <= '0;
            act_didx_q <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            sh_rule_q  <= sh_rule_d;
            sh_en_q    <= sh_en_d;
            sh_didx_q  <= sh_didx_d;
            act_rule_q <= act_rule_d;
            act_en_q   <= act_en_d;
            act_didx_q <= act_didx_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    for (genvar i = 0; i < NumSbrPorts; i++) begin : g_cnt
        obi_outstanding_cnt #(.NumMaxTrans(NumMaxTrans)) u_cnt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .req_i    (mon_req_i[i]),
            .gnt_i    (mon_gnt_i[i]),
            .rvalid_i (mon_rvalid_i[i]),
            .drain_i  (drain_next),
            .block_o  (block_o[i]),
            .idle_o   (idle[i])
        );
    end

    assign cfg_gnt_o        = cfg_req_i;
    assign cfg_rvalid_o     = rvalid_q;
    assign cfg_err_o        = err_q;
    assign cfg_rdata_o      = rdata_q;
    assign addr_map_o       = act_rule_q;
    assign en_default_idx_o = act_en_q;
    assign default_idx_o    = act_didx_q;

endmodule

// File: tb/tb_obi_addr_map_ctrl.sv
// tb_obi_addr_map_ctrl: directed self-checking bench for the address-map controller
module tb_obi_addr_map_ctrl;

    localparam int NS = 2, NM = 4, NR = 4, IW = 2, RW = IW + 64;

    logic              clk = 1'b0, rst_ni = 1'b0;
    logic              cfg_req = 1'b0, cfg_we = 1'b0;
    logic [11:0]       cfg_addr = '0;
    logic [31:0]       cfg_wdata = '0;
    logic              cfg_gnt, cfg_rvalid, cfg_err;
    logic [31:0]       cfg_rdata;
    logic [NS-1:0]     mon_req = '0, mon_gnt = '0, mon_rvalid = '0, block;
    logic [NR*RW-1:0]  addr_map, exp_map = '0;
    logic [NS-1:0]     en_def;
    logic [NS*IW-1:0]  def_idx;
    logic              busy;
    int                vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    obi_addr_map_ctrl #(
        .NumSbrPorts(NS), .NumMgrPorts(NM), .NumAddrRules(NR), .NumMaxTrans(4), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_req_i(cfg_req), .cfg_gnt_o(cfg_gnt), .cfg_addr_i(cfg_addr), .cfg_we_i(cfg_we),
        .cfg_wdata_i(cfg_wdata), .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
        .mon_req_i(mon_req), .mon_gnt_i(mon_gnt), .mon_rvalid_i(mon_rvalid), .block_o(block),
        .addr_map_o(addr_map), .en_default_idx_o(en_def), .default_idx_o(def_idx), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [NR*RW-1:0] obs, input logic [NR*RW-1:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input string tag, input logic we, input logic [11:0] a, input logic [31:0] wd,
                       input logic want_err, input logic [31:0] want_rd);
        cfg_req = 1'b1; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        #1 chk({tag, " gnt"}, cfg_gnt, 1);
        @(posedge clk);
        #1;
        cfg_req = 1'b0; cfg_we = 1'b0;
        chk({tag, " rvalid"}, cfg_rvalid, 1);
        chk({tag, " err"}, cfg_err, want_err);
        chk({tag, " rdata"}, cfg_rdata, want_rd);
    endtask

    task automatic xfer(input int p, input int n);
        mon_req[p] = 1'b1; mon_gnt[p] = 1'b1;
        repeat (n) tick();
        mon_req[p] = 1'b0; mon_gnt[p] = 1'b0;
    endtask

    task automatic rsp(input int p, input int n);
        mon_rvalid[p] = 1'b1;
        repeat (n) tick();
        mon_rvalid[p] = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst block", block, 0);
        chk("rst rvalid", cfg_rvalid, 0);
        chk("rst err", cfg_err, 0);
        chk("rst rdata", cfg_rdata, 0);
        chk("rst map", addr_map, 0);
        chk("rst en_def", en_def, 0);
        chk("rst def_idx", def_idx, 0);
        rst_ni = 1'b1;
        tick();

        // basic commit with no traffic
        cfg("wr r0 start", 1, 12'h000, 32'h1000, 0, 0);
        cfg("wr r0 end", 1, 12'h004, 32'h2000, 0, 0);
        cfg("wr r0 idx", 1, 12'h008, 32'h1, 0, 0);
        cfg("wr def_en", 1, 12'h808, 32'h3, 0, 0);
        cfg("wr def_idx1", 1, 12'h904, 32'h2, 0, 0);
        cfg("rd r0 start", 0, 12'h000, 0, 0, 32'h1000);
        cfg("rd r0 idx", 0, 12'h008, 0, 0, 32'h1);
        cfg("rd def_idx1", 0, 12'h904, 0, 0, 32'h2);
        cfg("rd status idle", 0, 12'h804, 0, 0, 0);
        chk("map before commit", addr_map, 0);
        cfg("commit1", 1, 12'h800, 1, 0, 0);
        chk("c1 drain busy", busy, 1);
        chk("c1 drain block", block, 2'b11);
        tick();
        chk("c1 rvalid low", cfg_rvalid, 0);
        chk("c1 commit busy", busy, 1);
        chk("c1 commit block", block, 0);
        chk("c1 commit map old", addr_map, 0);
        tick();
        exp_map[0 +: RW] = {2'd1, 32'h1000, 32'h2000};
        chk("c1 idle busy", busy, 0);
        chk("c1 map", addr_map, exp_map);
        chk("c1 en_def", en_def, 2'b11);
        chk("c1 def_idx", def_idx, 4'h8);

        // three outstanding on port 0
        xfer(0, 3);
        cfg("wr r1 start", 1, 12'h010, 32'h3000, 0, 0);
        cfg("wr r1 end", 1, 12'h014, 32'h4000, 0, 0);
        cfg("wr r1 idx", 1, 12'h018, 32'h2, 0, 0);
        cfg("commit2", 1, 12'h800, 1, 0, 0);
        tick();
        tick();
        chk("c2 waiting busy", busy, 1);
        chk("c2 waiting block", block, 2'b11);
        chk("c2 waiting map", addr_map, exp_map);
        rsp(0, 3);
        chk("c2 cnt0 busy", busy, 1);
        chk("c2 cnt0 map", addr_map, exp_map);
        tick();
        chk("c2 commit busy", busy, 1);
        chk("c2 commit block", block, 0);
        tick();
        exp_map[RW +: RW] = {2'd2, 32'h3000, 32'h4000};
        chk("c2 idle busy", busy, 0);
        chk("c2 map", addr_map, exp_map);

        // port 1 request pending without grant at commit
        cfg("wr def_en 1", 1, 12'h808, 32'h1, 0, 0);
        mon_req[1] = 1'b1;
        cfg("commit3", 1, 12'h800, 1, 0, 0);
        chk("c3 block p1 clear", block, 2'b01);
        tick();
        tick();
        chk("c3 block p1 still clear", block, 2'b01);
        mon_gnt[1] = 1'b1;
        tick();
        mon_req[1] = 1'b0; mon_gnt[1] = 1'b0;
        chk("c3 block after gnt", block, 2'b11);
        chk("c3 busy after gnt", busy, 1);
        rsp(1, 1);
        chk("c3 cnt0 busy", busy, 1);
        tick();
        chk("c3 commit en_def old", en_def, 2'b11);
        tick();
        chk("c3 idle busy", busy, 0);
        chk("c3 en_def", en_def, 2'b01);

        // commit while busy, bad addresses, shadow write during drain
        xfer(0, 1);
        cfg("commit4", 1, 12'h800, 1, 0, 0);
        cfg("commit4 again", 1, 12'h800, 1, 1, 0);
        cfg("rd unmapped", 0, 12'h7F0, 0, 1, 0);
        cfg("wr status", 1, 12'h804, 32'h3, 1, 0);
        cfg("rd status busy", 0, 12'h804, 0, 0, 32'h1);
        cfg("wr r2 start drain", 1, 12'h020, 32'h5000, 0, 0);
        chk("c4 still busy", busy, 1);
        rsp(0, 1);
        tick();
        chk("c4 commit busy", busy, 1);
        tick();
        exp_map[2*RW +: RW] = {2'd0, 32'h5000, 32'h0};
        chk("c4 idle busy", busy, 0);
        chk("c4 map", addr_map, exp_map);
        tick();
        chk("c4 single commit", busy, 0);

        // same-cycle grant and response at count 1, then a stuck drain
        xfer(0, 1);
        mon_req[0] = 1'b1; mon_gnt[0] = 1'b1; mon_rvalid[0] = 1'b1;
        tick();
        mon_req[0] = 1'b0; mon_gnt[0] = 1'b0; mon_rvalid[0] = 1'b0;
        cfg("wr r3 start", 1, 12'h030, 32'h7000, 0, 0);
        cfg("commit5", 1, 12'h800, 1, 0, 0);
        repeat (15) tick();
        chk("c5 drain busy", busy, 1);
`ifdef OBI_ADDR_MAP_CTRL_TIMEOUT_EN
        tick();
        chk("c5 timeout idle", busy, 0);
        chk("c5 timeout block", block, 0);
        chk("c5 timeout map", addr_map, exp_map);
        cfg("rd status timeout", 0, 12'h804, 0, 0, 32'h2);
        rsp(0, 1);
        cfg("commit5b", 1, 12'h800, 1, 0, 0);
        chk("c5b block", block, 2'b11);
        cfg("rd status cleared", 0, 12'h804, 0, 0, 32'h1);
        tick();
`else
        tick();
        chk("c5 still draining", busy, 1);
        chk("c5 block held", block, 2'b11);
        cfg("rd status no timeout", 0, 12'h804, 0, 0, 32'h1);
        rsp(0, 1);
        chk("c5 cnt0 busy", busy, 1);
        tick();
        chk("c5 commit busy", busy, 1);
        tick();
`endif
        exp_map[3*RW +: RW] = {2'd0, 32'h7000, 32'h0};
        chk("c5 idle busy", busy, 0);
        chk("c5 map", addr_map, exp_map);

        // asynchronous reset in the middle of a drain
        xfer(0, 1);
        cfg("commit6", 1, 12'h800, 1, 0, 0);
        chk("c6 drain busy", busy, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst block", block, 0);
        chk("arst map", addr_map, 0);
        chk("arst en_def", en_def, 0);
        chk("arst def_idx", def_idx, 0);
        #2 rst_ni = 1'b1;
        tick();
        cfg("rd r0 after arst", 0, 12'h000, 0, 0, 0);
        cfg("rd status after arst", 0, 12'h804, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
